// File: rtl/freq_to_fword.sv
// freq_to_fword: converts 0.1-Hz-unit frequency / code-rate words into DDS
// tuning words, word = floor(x * 2^FW / DIV_CONST), via a shared one-bit-per-
// clock restoring divider that runs the carrier and then the code rate.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   cfg_valid           level from the decoder; a rising edge requests a conversion
//   freq_in             carrier frequency, 0.1 Hz units
//   code_rate_in        code rate, 0.1 sym/s units
//   fword_freq          carrier tuning word (held between conversions)
//   fword_rate          code-rate tuning word (held between conversions)
//   fword_valid         one-cycle pulse when both words update
//   busy                high from the start edge until the fword_valid edge
//   range_err           sticky: last completed conversion had an input >= DIV_CONST
module freq_to_fword #(
  parameter int unsigned DIV_CONST = 500_000_000,
  parameter int unsigned FW        = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cfg_valid,
  input  logic [31:0]   freq_in,
  input  logic [31:0]   code_rate_in,
  output logic [FW-1:0] fword_freq,
  output logic [FW-1:0] fword_rate,
  output logic          fword_valid,
  output logic          busy,
  output logic          range_err
);

  // Remainder needs one bit above DIV_CONST's width to hold the doubled value.
  localparam int unsigned RW = $clog2(DIV_CONST) + 1;
  localparam int unsigned CW = $clog2(FW);
  localparam logic [RW-1:0] DIV_R    = RW'(DIV_CONST);
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV_F = 2'd1,
    S_DIV_R = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          v_d1_q, v_d2_q;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [FW-1:0] quo_q, quo_d;
  logic [FW-1:0] fquo_q, fquo_d;
  logic [RW-1:0] rate_lat_q, rate_lat_d;
  logic          clamp_f_q, clamp_f_d;
  logic          clamp_r_q, clamp_r_d;
  logic [FW-1:0] fword_freq_q, fword_freq_d;
  logic [FW-1:0] fword_rate_q, fword_rate_d;
  logic          fword_valid_q, fword_valid_d;
  logic          busy_q, busy_d;
  logic          range_err_q, range_err_d;

  logic          start_c;
  logic          f_ok_c, r_ok_c;
  logic [RW-1:0] rem2_c;
  logic          ge_c;
  logic [RW-1:0] rem_next_c;
  logic [FW-1:0] quo_next_c;

  // Two-stage delay: start fires one clock after v_d1 sees the rise, which
  // lets the decoder's data settle before sampling.
  assign start_c = v_d1_q & ~v_d2_q;

  assign f_ok_c = (freq_in      < DIV_CONST);
  assign r_ok_c = (code_rate_in < DIV_CONST);

  // One restoring-division step; rem_q < DIV_CONST so its MSB is always 0.
  assign rem2_c     = {rem_q[RW-2:0], 1'b0};
  assign ge_c       = (rem2_c >= DIV_R);
  assign rem_next_c = ge_c ? (rem2_c - DIV_R) : rem2_c;
  assign quo_next_c = {quo_q[FW-2:0], ge_c};

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      v_d1_q        <= 1'b0;
      v_d2_q        <= 1'b0;
      pend_q        <= 1'b0;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      fquo_q        <= '0;
      rate_lat_q    <= '0;
      clamp_f_q     <= 1'b0;
      clamp_r_q     <= 1'b0;
      fword_freq_q  <= '0;
      fword_rate_q  <= '0;
      fword_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_d1_q        <= cfg_valid;
      v_d2_q        <= v_d1_q;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      fquo_q        <= fquo_d;
      rate_lat_q    <= rate_lat_d;
      clamp_f_q     <= clamp_f_d;
      clamp_r_q     <= clamp_r_d;
      fword_freq_q  <= fword_freq_d;
      fword_rate_q  <= fword_rate_d;
      fword_valid_q <= fword_valid_d;
      busy_q        <= busy_d;
      range_err_q   <= range_err_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    fquo_d        = fquo_q;
    rate_lat_d    = rate_lat_q;
    clamp_f_d     = clamp_f_q;
    clamp_r_d     = clamp_r_q;
    fword_freq_d  = fword_freq_q;
    fword_rate_d  = fword_rate_q;
    fword_valid_d = 1'b0;
    busy_d        = busy_q;
    range_err_d   = range_err_q;

    // Starts arriving mid-conversion (including on DONE) merge into one pending request.
    if (start_c && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_c || pend_q) begin
          pend_d     = 1'b0;
          clamp_f_d  = ~f_ok_c;
          clamp_r_d  = ~r_ok_c;
          // Out-of-range inputs are clamped at DONE; divide zero to keep latency fixed.
          rem_d      = f_ok_c ? RW'(freq_in) : '0;
          rate_lat_d = r_ok_c ? RW'(code_rate_in) : '0;
          cnt_d      = '0;
          quo_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_DIV_F;
        end
      end
      S_DIV_F: begin
        rem_d = rem_next_c;
        quo_d = quo_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          fquo_d  = quo_next_c;
          rem_d   = rate_lat_q;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV_R;
        end
      end
      S_DIV_R: begin
        rem_d = rem_next_c;
        quo_d = quo_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        fword_freq_d  = clamp_f_q ? '1 : fquo_q;
        fword_rate_d  = clamp_r_q ? '1 : quo_q;
        fword_valid_d = 1'b1;
        busy_d        = 1'b0;
        range_err_d   = clamp_f_q | clamp_r_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fword_freq  = fword_freq_q;
  assign fword_rate  = fword_rate_q;
  assign fword_valid = fword_valid_q;
  assign busy        = busy_q;
  assign range_err   = range_err_q;

endmodule
